// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// Host-to-device transmitter for a PS/2 port. It sends one command byte
// using the request-to-send handshake: it holds the clock low, puts the
// start bit on data, releases the clock, then shifts out data (LSB first),
// odd parity and stop on each device falling clock edge, and finally checks
// the device ACK.
//
// Handshake: tx_valid/tx_ready. A byte is accepted in the cycle where both
// are 1. tx_ready is 1 only while idle; tx_valid while busy is ignored and
// not queued. Completion is reported by a one-cycle tx_done pulse; any
// failure (missing ACK or timeout) by a one-cycle tx_err pulse. The two
// pulses never coincide.
//
// Ports:
//   clk, rst      system clock and synchronous active-high reset
//   tx_data       command byte to send
//   tx_valid      request to send tx_data
//   tx_ready      idle, a byte can be accepted
//   tx_done       one-cycle pulse: byte ACKed and bus idle again
//   tx_err        one-cycle pulse: missing ACK or timeout
//   ps2_clk_in    raw PS2Clk line level
//   ps2_data_in   raw PS2Data line level
//   ps2_clk_oe    1 pulls PS2Clk low, 0 releases it
//   ps2_data_oe   1 pulls PS2Data low, 0 releases it
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int XFER_TIMEOUT_CYCLES  = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // One shared state-time counter, wide enough for the largest interval.
    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_REQ        = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_SHIFT      = 3'd4,
        ST_WAIT_IDLE  = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       edge_cnt_q;
    logic [7:0]       tx_byte_q;
    logic             parity_q;
    logic             done_q;
    logic             err_q;
    logic             done_d;
    logic             err_d;

    // clk_sync[1] is the synchronized clock, clk_sync[2] its previous value.
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_s;
    logic       data_s;
    logic       clk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = clk_sync[2] & ~clk_sync[1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; error and done are decided here so the pulse shows
    // up in the first IDLE cycle, together with the released lines.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) state_d = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (clk_fall) begin
                    state_d = ST_SHIFT;
                end else if (cnt_q == START_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                // edge_cnt_q == 10 means this fall is edge 11: the ACK slot.
                // A completing edge wins over a simultaneous timeout.
                if (clk_fall && edge_cnt_q == 4'd10) begin
                    if (!data_s) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (cnt_q == XFER_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == XFER_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: state-time counter, edge counter, latched byte and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            edge_cnt_q <= 4'd0;
            tx_byte_q  <= 8'd0;
            parity_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            // Cleared on every state entry and held at zero while idle.
            if (state_d != state_q || state_q == ST_IDLE) cnt_q <= '0;
            else                                           cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_IDLE && tx_valid) begin
                tx_byte_q <= tx_data;
                parity_q  <= ~^tx_data;
            end
            if (state_q == ST_WAIT_START && clk_fall)  edge_cnt_q <= 4'd1;
            else if (state_q == ST_SHIFT && clk_fall)  edge_cnt_q <= edge_cnt_q + 4'd1;
        end
    end

    // Output logic. In SHIFT the line carries the bit chosen by the last
    // falling edge: edges 1..8 data, 9 parity, 10 stop (released).
    always_comb begin
        tx_ready    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            ST_IDLE:       tx_ready = 1'b1;
            ST_INHIBIT:    ps2_clk_oe = 1'b1;
            ST_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            ST_WAIT_START: ps2_data_oe = 1'b1;
            ST_SHIFT: begin
                if (edge_cnt_q >= 4'd1 && edge_cnt_q <= 4'd8)
                    ps2_data_oe = ~tx_byte_q[3'(edge_cnt_q - 4'd1)];
                else if (edge_cnt_q == 4'd9)
                    ps2_data_oe = ~parity_q;
                else
                    ps2_data_oe = 1'b0;
            end
            default: begin
                tx_ready    = 1'b0;
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

    assign tx_done = done_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Testbench for ps2_host_tx. A behavioural PS/2 device drives the shared
// open-drain lines; directed steps cover ACKed sends, parity, NACK, start
// timeout, reset mid-transfer and a request dropped while busy.
module tb_ps2_host_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    // Device side of the open-drain bus (1 = released).
    logic dev_clk;
    logic dev_data;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (20),
        .START_TIMEOUT_CYCLES(500),
        .XFER_TIMEOUT_CYCLES (5000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitors ----------------
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int inh_cnt  = 0;
    int ws_cnt   = 0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_err === 1'b1)  err_cnt  <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) ws_cnt  <= ws_cnt + 1;
    end

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send (clock released, data low), samples
    // the start bit, then produces n_edges falling edges, sampling data on
    // each rising edge. On edge 11 it pulls data low first when do_ack is set.
    // frame ends with bit 0 = start ... bit 10 = stop after a full run.
    logic [10:0] dev_frame;

    task automatic dev_xfer(input bit do_ack, input int n_edges, output bit ok);
        int guard;
        ok    = 1'b1;
        guard = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) begin
            ok = 1'b0;
            return;
        end
        tick(10);
        dev_frame = {ps2_data_in, dev_frame[10:1]};
        for (int n = 1; n <= n_edges; n++) begin
            if (n == 11 && do_ack) begin
                dev_data = 1'b0;
                tick(5);
            end
            dev_clk = 1'b0;
            tick(20);
            dev_clk = 1'b1;
            if (n <= 10) dev_frame = {ps2_data_in, dev_frame[10:1]};
            if (n == 11) dev_data = 1'b1;
            tick(20);
        end
    endtask

    // ---------------- directed sequence ----------------
    int done0, err0, inh0, ws0, both0;
    int guard;
    bit ok;

    initial begin
        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        dev_clk   = 1'b1;
        dev_data  = 1'b1;
        dev_frame = '0;
        tick(3);
        check("rst_ready",   32'(tx_ready),    32'd1);
        check("rst_done",    32'(tx_done),     32'd0);
        check("rst_err",     32'(tx_err),      32'd0);
        check("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        tick(5);

        // 0xF4 ACKed: start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1
        done0 = done_cnt; err0 = err_cnt; inh0 = inh_cnt;
        start_tx(8'hF4);
        check("f4_busy", 32'(tx_ready), 32'd0);
        dev_xfer(1'b1, 11, ok);
        check("f4_dev_ok",  32'(ok),             32'd1);
        check("f4_frame",   32'(dev_frame),      32'h5E8);
        check("f4_inhibit", 32'(inh_cnt - inh0), 32'd20);
        check("f4_done",    32'(done_cnt - done0), 32'd1);
        check("f4_err",     32'(err_cnt - err0),   32'd0);
        check("f4_ready",   32'(tx_ready),       32'd1);
        tick(5);

        // 0xFF ACKed: parity 1
        done0 = done_cnt; err0 = err_cnt;
        start_tx(8'hFF);
        dev_xfer(1'b1, 11, ok);
        check("ff_dev_ok", 32'(ok),               32'd1);
        check("ff_frame",  32'(dev_frame),        32'h7FE);
        check("ff_done",   32'(done_cnt - done0), 32'd1);
        check("ff_err",    32'(err_cnt - err0),   32'd0);
        check("ff_ready",  32'(tx_ready),         32'd1);
        tick(5);

        // 0x55 with data left high at edge 11: NACK error
        done0 = done_cnt; err0 = err_cnt;
        start_tx(8'h55);
        dev_xfer(1'b0, 11, ok);
        check("nack_dev_ok",  32'(ok),               32'd1);
        check("nack_frame",   32'(dev_frame),        32'h6AA);
        check("nack_err",     32'(err_cnt - err0),   32'd1);
        check("nack_done",    32'(done_cnt - done0), 32'd0);
        check("nack_clk_oe",  32'(ps2_clk_oe),       32'd0);
        check("nack_data_oe", 32'(ps2_data_oe),      32'd0);
        check("nack_ready",   32'(tx_ready),         32'd1);
        tick(5);

        // Device never clocks: error after 500 cycles in WAIT_START
        done0 = done_cnt; err0 = err_cnt; ws0 = ws_cnt;
        start_tx(8'h12);
        guard = 0;
        while (err_cnt == err0 && guard < 1000) begin
            tick(1);
            guard++;
        end
        check("tmo_in_budget", 32'(guard < 1000),    32'd1);
        check("tmo_wait_len",  32'(ws_cnt - ws0),    32'd500);
        check("tmo_err",       32'(err_cnt - err0),  32'd1);
        check("tmo_done",      32'(done_cnt - done0), 32'd0);
        check("tmo_clk_oe",    32'(ps2_clk_oe),      32'd0);
        check("tmo_data_oe",   32'(ps2_data_oe),     32'd0);
        tick(5);

        // Reset after edge 4 of 0x3C: bit 3 is 1, so data is released
        done0 = done_cnt; err0 = err_cnt;
        start_tx(8'h3C);
        dev_xfer(1'b1, 4, ok);
        check("rmid_dev_ok",    32'(ok),          32'd1);
        check("rmid_busy",      32'(tx_ready),    32'd0);
        check("rmid_bit3_oe",   32'(ps2_data_oe), 32'd0);
        rst = 1'b1;
        tick(1);
        check("rmid_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("rmid_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rmid_ready",   32'(tx_ready),    32'd1);
        rst = 1'b0;
        tick(10);
        check("rmid_no_done", 32'(done_cnt - done0), 32'd0);
        check("rmid_no_err",  32'(err_cnt - err0),   32'd0);

        // 0xAA requested while 0xF4 is in flight is dropped
        done0 = done_cnt; err0 = err_cnt; inh0 = inh_cnt;
        start_tx(8'hF4);
        tick(5);
        start_tx(8'hAA);
        dev_xfer(1'b1, 11, ok);
        tick(100);
        check("drop_dev_ok",  32'(ok),               32'd1);
        check("drop_frame",   32'(dev_frame),        32'h5E8);
        check("drop_done",    32'(done_cnt - done0), 32'd1);
        check("drop_err",     32'(err_cnt - err0),   32'd0);
        check("drop_one_req", 32'(inh_cnt - inh0),   32'd20);
        check("drop_ready",   32'(tx_ready),         32'd1);

        both0 = both_cnt;
        check("never_both", 32'(both0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
